// File: rtl/boot_loader.sv
// Framed byte-stream image loader: holds the core in reset, writes little-endian
// words to memory from address 0, checks an XOR checksum, then releases the core.
//
// state  | meaning
// S_LEN  | collecting the 4-byte little-endian word count N
// S_DATA | collecting payload bytes, one memory write per completed word
// S_CSUM | waiting for the checksum byte
// S_DONE | image accepted, core released (terminal)
// S_ERR  | length or checksum failure (terminal)
module boot_loader #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_reset,
   output logic        done,
   output logic        error
);

   localparam int IW = $clog2(MEM_WORDS) + 1;

   typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [31:0]   len_q, len_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [IW-1:0] word_idx_q, word_idx_d;
   logic [7:0]    csum_q, csum_d;
   logic [23:0]   word_q, word_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;

   logic          active;
   logic          xfer;
   logic [31:0]   len_full;
   logic [31:0]   word_full;
   logic [31:0]   idx_next_ext;

   assign active    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign in_ready  = active && !reset;
   assign xfer      = in_valid && in_ready;
   // Bytes arrive LSB first, so shift each new byte in from the top.
   assign len_full  = {in_byte, len_q[31:8]};
   assign word_full = {in_byte, word_q};
   assign idx_next_ext = {{(32-IW){1'b0}}, word_idx_q} + 32'd1;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      csum_d      = csum_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_LEN: begin
            if (xfer) begin
               len_d      = len_full;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (len_full > 32'(MEM_WORDS)) state_d = S_ERR;
                  else if (len_full == 32'd0)    state_d = S_CSUM;
                  else                           state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d     = word_full[31:8];
               csum_d     = csum_q ^ in_byte;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {{(32-IW-2){1'b0}}, word_idx_q, 2'b00};
                  mem_wdata_d = word_full;
                  word_idx_d  = word_idx_q + {{(IW-1){1'b0}}, 1'b1};
                  if (idx_next_ext == len_q) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (xfer) state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LEN;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         csum_q      <= '0;
         word_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         csum_q      <= csum_d;
         word_q      <= word_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign core_reset = (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames are driven byte by byte and the
// observed memory writes and status outputs are compared to hand-computed values.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_byte = 8'h00;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_reset;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  frm[$];

   boot_loader #(.MEM_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge after the reset edge.
   task automatic do_reset(input bit check);
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      if (check) begin
         chk("rst_in_ready", 32'(in_ready), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_core_reset", 32'(core_reset), 32'd1);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_error", 32'(error), 32'd0);
      end
      reset = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      #1;
      if (check) chk("rst_release_ready", 32'(in_ready), 32'd1);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int idle);
      int n;
      in_valid = 1'b0;
      for (int i = 0; i < idle; i++) @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      n = 0;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_idle);
      for (int i = 0; i < frm.size(); i++)
         send_byte(frm[i], (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0);
   endtask

   task automatic chk_two_writes(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() >= 2) begin
         chk({tag, "_wr0_addr"}, wr_addr_q[0], 32'h0000_0000);
         chk({tag, "_wr0_data"}, wr_data_q[0], 32'h0050_0093);
         chk({tag, "_wr1_addr"}, wr_addr_q[1], 32'h0000_0004);
         chk({tag, "_wr1_data"}, wr_data_q[1], 32'h00A0_0113);
      end
   endtask

   task automatic chk_status(input string tag, input logic d, input logic e, input logic cr);
      chk({tag, "_done"}, 32'(done), 32'(d));
      chk({tag, "_error"}, 32'(error), 32'(e));
      chk({tag, "_core_reset"}, 32'(core_reset), 32'(cr));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      @(negedge clk);
      do_reset(1'b1);

      // 1: two-word image, good checksum
      frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
      send_frame(0);
      chk_two_writes("t1");
      chk_status("t1", 1'b1, 1'b0, 1'b0);

      // 2: bad checksum, then extra bytes must be ignored
      do_reset(1'b1);
      frm[12] = 8'h70;
      send_frame(0);
      chk_two_writes("t2");
      chk_status("t2", 1'b0, 1'b1, 1'b1);
      in_valid = 1'b1;
      in_byte  = 8'h55;
      repeat (8) @(negedge clk);
      in_valid = 1'b0;
      chk("t2_extra_wr_count", 32'(wr_addr_q.size()), 32'd2);
      chk_status("t2_after", 1'b0, 1'b1, 1'b1);

      // 3: length 257 rejected
      do_reset(1'b0);
      frm = '{8'h01, 8'h01, 8'h00, 8'h00};
      send_frame(0);
      chk_status("t3", 1'b0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      chk("t3_wr_count", 32'(wr_addr_q.size()), 32'd0);

      // 3b: length exactly 256 accepted into the data phase
      do_reset(1'b0);
      frm = '{8'h00, 8'h01, 8'h00, 8'h00};
      send_frame(0);
      chk("t3b_error", 32'(error), 32'd0);
      chk("t3b_in_ready", 32'(in_ready), 32'd1);

      // 4: empty image
      do_reset(1'b0);
      frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0);
      chk_status("t4", 1'b1, 1'b0, 1'b0);
      chk("t4_wr_count", 32'(wr_addr_q.size()), 32'd0);

      do_reset(1'b0);
      frm[4] = 8'h01;
      send_frame(0);
      chk_status("t4b", 1'b0, 1'b1, 1'b1);
      chk("t4b_wr_count", 32'(wr_addr_q.size()), 32'd0);

      // 5: test-1 frame with random idle gaps
      do_reset(1'b0);
      frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
      send_frame(5);
      chk_two_writes("t5");
      chk_status("t5", 1'b1, 1'b0, 1'b0);

      // 6: reset mid-word, then a clean frame
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) send_byte(frm[i], 0);
      chk("t6_partial_wr_count", 32'(wr_addr_q.size()), 32'd0);
      do_reset(1'b1);
      send_frame(0);
      chk_two_writes("t6");
      chk_status("t6", 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
